// File: rtl/mdu_pkg.sv
// mdu_pkg: funct3 codes, state encoding and word width shared by the MDU and its decoder.
package mdu_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    OP_MUL    = F3_MUL,
    OP_MULH   = F3_MULH,
    OP_MULHSU = F3_MULHSU,
    OP_MULHU  = F3_MULHU,
    OP_DIV    = F3_DIV,
    OP_DIVU   = F3_DIVU,
    OP_REM    = F3_REM,
    OP_REMU   = F3_REMU
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: issue/result handshakes plus pipeline flush between EX and the MDU.
interface mdu_iter_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            is_word;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [RD_W-1:0] rd_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;

  modport master (
    output flush, in_valid, op, is_word, rs1_data, rs2_data, rd_in, out_ready,
    input  in_ready, out_valid, result, rd_out
  );

  modport slave (
    input  flush, in_valid, op, is_word, rs1_data, rs2_data, rd_in, out_ready,
    output in_ready, out_valid, result, rd_out
  );

endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division step; shifts the next dividend bit into the
// partial remainder and emits one quotient bit.
module mdu_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // One extra bit so a borrow out of the trial subtraction is visible.
  assign w_shift = {i_rem, i_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_rem   = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_quot  = {i_quot[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit, one radix-2 step per cycle.
// Optional macro MDU_EARLY_OUT_EN: zero multiply operands and divide-by-zero bypass CALC.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RD_W  = 5,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);

  localparam logic [CNT_W-1:0] ITER_X = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] ITER_W = CNT_W'(WORD_W);

  mdu_state_e        r_state;
  mdu_state_e        w_next;
  mdu_op_e           r_op;
  logic              r_word;
  logic              r_resNeg;
  logic              r_remNeg;
  logic              r_divZero;
  logic              r_ovf;
  logic [RD_W-1:0]   r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvd;
  logic [XLEN-1:0]   r_result;

  logic              w_isDiv;
  logic              w_word;
  logic              w_aSigned;
  logic              w_bSigned;
  logic              w_aNeg;
  logic              w_bNeg;
  logic              w_early;
  logic              w_accept;
  logic              w_step;
  logic              w_fix;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [XLEN-1:0]   w_aMag;
  logic [XLEN-1:0]   w_bMag;
  logic [XLEN-1:0]   w_minNeg;
  logic [XLEN-1:0]   w_stepRem;
  logic [XLEN-1:0]   w_stepQuot;
  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_mulRes;
  logic [XLEN-1:0]   w_quotFix;
  logic [XLEN-1:0]   w_remFix;
  logic [XLEN-1:0]   w_divRes;
  logic [XLEN-1:0]   w_fixRes;

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic s);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = WORD_W; i < XLEN; i++) r[i] = s & v[WORD_W-1];
    return r;
  endfunction

  // Operand decode: *W only exists for MUL and the divides, and never on RV32.
  always_comb begin
    w_isDiv   = op_is_div(bus.op);
    w_word    = (XLEN > WORD_W) && bus.is_word && (w_isDiv || bus.op == F3_MUL);
    w_aSigned = w_isDiv ? !bus.op[0] : (bus.op[1:0] != 2'b11);
    w_bSigned = w_isDiv ? !bus.op[0] : !bus.op[1];
    w_a       = w_word ? ext32(bus.rs1_data, w_aSigned) : bus.rs1_data;
    w_b       = w_word ? ext32(bus.rs2_data, w_bSigned) : bus.rs2_data;
    w_aNeg    = w_aSigned && w_a[XLEN-1];
    w_bNeg    = w_bSigned && w_b[XLEN-1];
    w_aMag    = w_aNeg ? -w_a : w_a;
    w_bMag    = w_bNeg ? -w_b : w_b;
    w_minNeg  = w_word ? ext32(XLEN'(1) << (WORD_W - 1), 1'b1) : XLEN'(1) << (XLEN - 1);
  end

`ifdef MDU_EARLY_OUT_EN
  assign w_early = w_isDiv ? (w_b == '0) : (w_a == '0 || w_b == '0);
`else
  assign w_early = 1'b0;
`endif

  mdu_div_step #(.XLEN(XLEN)) u_divStep (
    .i_rem    (r_rem),
    .i_quot   (r_quot),
    .i_divisor(r_b),
    .o_rem    (w_stepRem),
    .o_quot   (w_stepQuot)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Flush overrides everything, including an accept or a result handshake.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_fix    = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.in_valid) begin
        w_accept = 1'b1;
        w_next   = w_early ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next = ST_FIX;
      end
      ST_FIX: begin
        w_fix  = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (bus.flush) begin
      w_next   = ST_IDLE;
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_fix    = 1'b0;
    end
  end

  // Sign correction and RISC-V divide special cases, then half select / word extension.
  always_comb begin
    w_prodFix = r_resNeg ? -r_prod : r_prod;
    w_mulRes  = (r_op == OP_MUL) ? w_prodFix[XLEN-1:0] : w_prodFix[2*XLEN-1:XLEN];
    w_quotFix = r_resNeg ? -r_quot : r_quot;
    w_remFix  = r_remNeg ? -r_rem : r_rem;
    if (r_divZero) begin
      w_quotFix = '1;
      w_remFix  = r_dvd;
    end else if (r_ovf) begin
      w_quotFix = r_dvd;
      w_remFix  = '0;
    end
    w_divRes = r_op[1] ? w_remFix : w_quotFix;
    w_fixRes = r_op[2] ? w_divRes : w_mulRes;
    if (r_word) w_fixRes = ext32(w_fixRes, 1'b1);
  end

  // Word divides pre-shift the dividend so 32 steps consume exactly its low half.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= OP_MUL;
      r_word    <= 1'b0;
      r_resNeg  <= 1'b0;
      r_remNeg  <= 1'b0;
      r_divZero <= 1'b0;
      r_ovf     <= 1'b0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_b       <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= mdu_op_e'(bus.op);
        r_word    <= w_word;
        r_resNeg  <= w_aNeg ^ w_bNeg;
        r_remNeg  <= w_aNeg;
        r_divZero <= w_isDiv && (w_b == '0);
        r_ovf     <= w_isDiv && w_aSigned && (w_a == w_minNeg) && (&w_b);
        r_rd      <= bus.rd_in;
        r_cnt     <= w_word ? ITER_W : ITER_X;
        r_mcand   <= {{XLEN{1'b0}}, w_aMag};
        r_prod    <= '0;
        r_b       <= w_bMag;
        r_quot    <= w_word ? (w_aMag << (XLEN - WORD_W)) : w_aMag;
        r_rem     <= '0;
        r_dvd     <= w_a;
      end
      if (w_step) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_op[2]) begin
          r_rem  <= w_stepRem;
          r_quot <= w_stepQuot;
        end else begin
          if (r_b[0]) r_prod <= r_prod + r_mcand;
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
        end
      end
      if (w_fix) r_result <= w_fixRes;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.result    = r_result;
  assign bus.rd_out    = r_rd;

endmodule
